// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver. It scans DIGITS digits one slot at a time,
// snapshots its inputs once per frame, and supports per-digit blink and decimal point.
module seg7_scan_display #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 25000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [5*DIGITS-1:0]   digit_val,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     seg_en,
    output logic [7:0]            seg_out,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic [5*DIGITS-1:0]   shd_val;
    logic [DIGITS-1:0]     shd_dp;
    logic [DIGITS-1:0]     shd_blink;

    logic                  tick;
    logic                  frame_tick;
    logic [IW-1:0]         idx_next;
    logic [4:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  blanked;
    logic [6:0]            glyph;
    logic [7:0]            seg_out_d;
    logic [DIGITS-1:0]     seg_en_d;

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'b0111111;
            5'd1:    g = 7'b0000110;
            5'd2:    g = 7'b1011011;
            5'd3:    g = 7'b1001111;
            5'd4:    g = 7'b1100110;
            5'd5:    g = 7'b1101101;
            5'd6:    g = 7'b1111101;
            5'd7:    g = 7'b0000111;
            5'd8:    g = 7'b1111111;
            5'd9:    g = 7'b1101111;
            5'd10:   g = 7'b1110111;
            5'd11:   g = 7'b1111100;
            5'd12:   g = 7'b0111001;
            5'd13:   g = 7'b1011110;
            5'd14:   g = 7'b1111001;
            5'd15:   g = 7'b1110001;
            5'd16:   g = 7'b1110110;
            5'd17:   g = 7'b1000000;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    assign tick       = (pcnt == PCNT_MAX);
    assign frame_tick = tick && (idx == '0);
    assign idx_next   = (idx == IDX_MAX) ? '0 : idx + IW'(1);

    // Digit 0 is decoded from the live inputs so it matches the snapshot taken on the same edge.
    always_comb begin
        cur_code  = digit_val[4:0];
        cur_dp    = dp_mask[0];
        cur_blink = blink_mask[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = shd_val[5*i +: 5];
                cur_dp    = shd_dp[i];
                cur_blink = shd_blink[i];
            end
        end
    end

    always_comb begin
        blanked   = cur_blink & phase;
        glyph     = decode(cur_code);
        seg_out_d = ~{cur_dp & ~blanked, glyph & {7{~blanked}}};
        seg_en_d  = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pcnt        <= '0;
            idx         <= '0;
            fcnt        <= '0;
            phase       <= 1'b0;
            shd_val     <= {DIGITS{5'd31}};
            shd_dp      <= '0;
            shd_blink   <= '0;
            seg_en      <= '1;
            seg_out     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                pcnt    <= '0;
                idx     <= idx_next;
                seg_en  <= seg_en_d;
                seg_out <= seg_out_d;
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            // The frame's own outputs above already used the pre-update phase.
            if (frame_tick) begin
                shd_val     <= digit_val;
                shd_dp      <= dp_mask;
                shd_blink   <= blink_mask;
                frame_start <= 1'b1;
                if (fcnt == FCNT_MAX) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a 4-digit instance and a 1-digit instance,
// with hand-computed expected segment patterns per scenario.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic        en;
    logic [19:0] digit_val;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  seg_en;
    logic [7:0]  seg_out;
    logic        frame_start;

    logic        rst_b;
    logic        en_b;
    logic [4:0]  digit_val_b;
    logic [0:0]  dp_mask_b;
    logic [0:0]  blink_mask_b;
    logic [0:0]  seg_en_b;
    logic [7:0]  seg_out_b;
    logic        frame_start_b;

    int checks;
    int errors;
    int cyc;

    seg7_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .digit_val(digit_val), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .seg_en(seg_en), .seg_out(seg_out), .frame_start(frame_start)
    );

    seg7_scan_display #(.DIGITS(1), .SCAN_DIV(2)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .digit_val(digit_val_b), .dp_mask(dp_mask_b),
        .blink_mask(blink_mask_b), .seg_en(seg_en_b), .seg_out(seg_out_b), .frame_start(frame_start_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; afterwards the bench is in cycle cyc.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Reset, then raise en so the next edge is cycle 0.
    task automatic start(input logic [19:0] v, input logic [3:0] dp, input logic [3:0] bl);
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst        = 1'b0;
        en         = 1'b1;
        digit_val  = v;
        dp_mask    = dp;
        blink_mask = bl;
        cyc        = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        step();
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1111, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %b %h %b want 1111 ff 0", seg_en, seg_out, frame_start);
        end
    endtask

    task automatic test_scan();
        start({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        run_to(3);
        checks++;
        if ({seg_en, seg_out} !== {4'b1111, 8'hFF}) begin
            errors++;
            $display("FAIL scan_before_first_tick got %b %h want 1111 ff", seg_en, seg_out);
        end
        run_to(4);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1110, 8'hC0, 1'b1}) begin
            errors++;
            $display("FAIL scan_c4 got %b %h %b want 1110 c0 1", seg_en, seg_out, frame_start);
        end
        run_to(7);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1110, 8'hC0, 1'b0}) begin
            errors++;
            $display("FAIL scan_hold_c7 got %b %h %b want 1110 c0 0", seg_en, seg_out, frame_start);
        end
        run_to(8);
        checks++;
        if ({seg_en, seg_out} !== {4'b1101, 8'hF9}) begin
            errors++;
            $display("FAIL scan_c8 got %b %h want 1101 f9", seg_en, seg_out);
        end
        run_to(12);
        checks++;
        if ({seg_en, seg_out} !== {4'b1011, 8'hA4}) begin
            errors++;
            $display("FAIL scan_c12 got %b %h want 1011 a4", seg_en, seg_out);
        end
        run_to(16);
        checks++;
        if ({seg_en, seg_out} !== {4'b0111, 8'hB0}) begin
            errors++;
            $display("FAIL scan_c16 got %b %h want 0111 b0", seg_en, seg_out);
        end
        run_to(20);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1110, 8'hC0, 1'b1}) begin
            errors++;
            $display("FAIL scan_c20 got %b %h %b want 1110 c0 1", seg_en, seg_out, frame_start);
        end
    endtask

    task automatic test_snapshot();
        start({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        run_to(10);
        digit_val[19:15] = 5'd16;
        run_to(16);
        checks++;
        if ({seg_en, seg_out} !== {4'b0111, 8'hB0}) begin
            errors++;
            $display("FAIL snap_old_c16 got %b %h want 0111 b0", seg_en, seg_out);
        end
        run_to(28);
        checks++;
        if ({seg_en, seg_out} !== {4'b1011, 8'hA4}) begin
            errors++;
            $display("FAIL snap_c28 got %b %h want 1011 a4", seg_en, seg_out);
        end
        run_to(32);
        checks++;
        if ({seg_en, seg_out} !== {4'b0111, 8'h89}) begin
            errors++;
            $display("FAIL snap_new_c32 got %b %h want 0111 89", seg_en, seg_out);
        end
    endtask

    task automatic test_dp_blank();
        start({5'd31, 5'd20, 5'd17, 5'd0}, 4'b0010, 4'b0000);
        run_to(8);
        checks++;
        if ({seg_en, seg_out} !== {4'b1101, 8'h3F}) begin
            errors++;
            $display("FAIL dp_dash got %b %h want 1101 3f", seg_en, seg_out);
        end
        run_to(12);
        checks++;
        if ({seg_en, seg_out} !== {4'b1011, 8'hFF}) begin
            errors++;
            $display("FAIL blank_code got %b %h want 1011 ff", seg_en, seg_out);
        end
    endtask

    task automatic test_blink();
        start({5'd31, 5'd31, 5'd1, 5'd8}, 4'b0001, 4'b0001);
        run_to(4);
        checks++;
        if ({seg_en, seg_out} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL blink_f0 got %b %h want 1110 00", seg_en, seg_out);
        end
        run_to(20);
        checks++;
        if ({seg_en, seg_out} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL blink_f1 got %b %h want 1110 00", seg_en, seg_out);
        end
        run_to(36);
        checks++;
        if ({seg_en, seg_out} !== {4'b1110, 8'hFF}) begin
            errors++;
            $display("FAIL blink_f2_off got %b %h want 1110 ff", seg_en, seg_out);
        end
        run_to(40);
        checks++;
        if ({seg_en, seg_out} !== {4'b1101, 8'hF9}) begin
            errors++;
            $display("FAIL blink_f2_other got %b %h want 1101 f9", seg_en, seg_out);
        end
        run_to(52);
        checks++;
        if ({seg_en, seg_out} !== {4'b1110, 8'hFF}) begin
            errors++;
            $display("FAIL blink_f3_off got %b %h want 1110 ff", seg_en, seg_out);
        end
        run_to(68);
        checks++;
        if ({seg_en, seg_out} !== {4'b1110, 8'h00}) begin
            errors++;
            $display("FAIL blink_f4 got %b %h want 1110 00", seg_en, seg_out);
        end
    endtask

    task automatic test_enable_reset();
        start({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
        run_to(9);
        en = 1'b0;
        run_to(10);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1111, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL en_off_c10 got %b %h %b want 1111 ff 0", seg_en, seg_out, frame_start);
        end
        run_to(15);
        en = 1'b1;
        run_to(18);
        checks++;
        if ({seg_en, seg_out} !== {4'b1111, 8'hFF}) begin
            errors++;
            $display("FAIL en_restart_c18 got %b %h want 1111 ff", seg_en, seg_out);
        end
        run_to(19);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1110, 8'hC0, 1'b1}) begin
            errors++;
            $display("FAIL en_restart_c19 got %b %h %b want 1110 c0 1", seg_en, seg_out, frame_start);
        end
        run_to(25);
        rst = 1'b1;
        run_to(26);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1111, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_c26 got %b %h %b want 1111 ff 0", seg_en, seg_out, frame_start);
        end
        rst = 1'b0;
        run_to(30);
        checks++;
        if ({seg_en, seg_out, frame_start} !== {4'b1110, 8'hC0, 1'b1}) begin
            errors++;
            $display("FAIL rst_restart_c30 got %b %h %b want 1110 c0 1", seg_en, seg_out, frame_start);
        end
    endtask

    task automatic test_single_digit();
        rst_b = 1'b1;
        en_b  = 1'b0;
        step();
        step();
        rst_b       = 1'b0;
        en_b        = 1'b1;
        digit_val_b = 5'd5;
        cyc         = 0;
        run_to(2);
        for (int c = 2; c < 8; c++) begin
            checks++;
            if ({seg_en_b, seg_out_b, frame_start_b} !== {1'b0, 8'h92, ((c % 2) == 0) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL single_c%0d got %b %h %b want 0 92 %0d", c, seg_en_b, seg_out_b,
                         frame_start_b, ((c % 2) == 0) ? 1 : 0);
            end
            step();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst          = 1'b1;
        en           = 1'b0;
        digit_val    = '0;
        dp_mask      = '0;
        blink_mask   = '0;
        rst_b        = 1'b1;
        en_b         = 1'b0;
        digit_val_b  = '0;
        dp_mask_b    = '0;
        blink_mask_b = '0;
        #2;
        test_reset();
        test_scan();
        test_snapshot();
        test_dp_blank();
        test_blink();
        test_enable_reset();
        test_single_digit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised, time-multiplexed seven-segment display driver for the vending-machine front panel. It generalises the fixed 8-digit sold-count display to:

- a configurable digit count and scan rate;
- a 5-bit per-digit glyph code, with per-digit decimal point and blink;
- frame-coherent input snapshotting, so a value change never tears mid-frame.

It sits between the machine/counter logic and the board's active-low digit-enable and segment pins.

## Interface

Parameters:
- DIGITS, 8, number of digits scanned, legal 1..8.
- SCAN_DIV, 25000, clk cycles per digit slot, legal ≥2.
- BLINK_FRAMES, 64, frames per blink half-period, legal ≥1.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable.
- digit_val  in  5*DIGITS  glyph code per digit; digit i = bits [5i+4:5i]; digit 0 is rightmost.
- dp_mask  in  DIGITS  bit i lights the decimal point of digit i.
- blink_mask  in  DIGITS  bit i makes digit i blink.
- seg_en  out  DIGITS  digit enables, active-low, one-hot-low when active.
- seg_out  out  8  segments, active-low, bit7=dp, bits6..0 = g,f,e,d,c,b,a.
- frame_start  out  1  one-cycle pulse when digit 0 is driven with a fresh snapshot.

## Operation

Glyph codes (active-high pattern g..a before inversion):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- 10(A)=1110111, 11(b)=1111100, 12(C)=0111001, 13(d)=1011110, 14(E)=1111001, 15(F)=1110001
- 16(H)=1110110, 17(-)=1000000
- 18..31 = blank (0000000)

Prescaler and scan:
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps; "tick" = cycle with pcnt==SCAN_DIV-1.
- Index `idx` names the digit loaded on the next tick.
- On each tick, outputs are registered for digit idx; idx then advances, wrapping from DIGITS-1 to 0.

Snapshot:
- On a tick with idx==0 (frame tick), digit_val, dp_mask and blink_mask are latched into shadow registers.
- Digit 0's outputs on that tick are decoded directly from the live inputs, i.e. the same values just latched.
- Digits 1..DIGITS-1 are decoded from the shadow registers.
- Input changes between frame ticks are invisible until the next frame.

Blink:
- Frame counter `fcnt` (0..BLINK_FRAMES-1) and `phase` bit.
- On a frame tick: if fcnt==BLINK_FRAMES-1, then fcnt←0 and phase←~phase; else fcnt←fcnt+1.
- The frame's outputs use the pre-update phase.
- When phase==1, a digit with its blink bit set drives all segments off, including dp; its seg_en is still asserted.

Output composition:
- seg_out = ~{dp & ~blanked, glyph & ~blanked}.
- seg_en = ~(1<<digit).

Enable:
- en=0 forces seg_en = all ones and seg_out = 8'hFF from the next edge.
- en=0 also holds pcnt, idx, fcnt and phase at their reset values and clears the shadows.
- Re-asserting en restarts exactly as after reset.

## Timing

- Reset values:
  - Outputs: seg_en all ones, seg_out 8'hFF, frame_start 0.
  - State: pcnt 0, idx 0, fcnt 0, phase 0.
  - Shadows: digit codes 31 (blank), masks 0.
- Rst has priority over en.
- Rst asserted mid-frame returns everything to reset values on the next edge.
- Cycle 0 is the first edge with rst=0 and en=1:
  - pcnt=0 in cycle 0; first tick in cycle SCAN_DIV-1.
  - Digit 0 appears, with frame_start=1, in cycle SCAN_DIV.
- Each digit is held exactly SCAN_DIV cycles.
- A full frame is DIGITS*SCAN_DIV cycles.
- frame_start is high for exactly one cycle per frame.
- Outputs are fully registered: no combinational path from inputs to seg_en or seg_out.
- DIGITS=1: every tick is a frame tick and digit 0 is always live-sampled.
- Width of pcnt = clog2(SCAN_DIV); width of idx = max(1, clog2(DIGITS)).

## Test plan

Unless stated, DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.

1. Scan order: reset, then digit_val = {3,2,1,0}, en=1.
   - Cycle 4: seg_en=1110, seg_out=~0x3F, frame_start=1.
   - Cycle 8: seg_en=1101, seg_out=~0x06.
   - Cycle 20: back to 1110.
2. Snapshot coherence: change digit 3 from 3 to 16 (H) at cycle 10.
   - Cycle 16 still shows ~0x4F on seg_en=0111.
   - Digit 3 shows ~0x76 only from cycle 32.
3. Decimal point and blank: digit_val digit1=17, digit2=20, dp_mask=0010.
   - Digit 1 drives seg_out=~0xC0.
   - Digit 2 drives seg_out=8'hFF with seg_en=1011.
4. Blink: blink_mask=0001, digit0=8.
   - Frames 0–1: digit 0 shows ~0x7F.
   - Frames 2–3: seg_out=8'hFF with seg_en=1110.
   - Frame 4: ~0x7F again.
5. Enable and reset mid-frame:
   - Drop en at cycle 9: from cycle 10, seg_en=1111 and seg_out=FF. Raise en at cycle 15: digit 0 at cycle 19.
   - Assert rst at cycle 25 with en=1: reset values at cycle 26.
6. DIGITS=1, SCAN_DIV=2: frame_start pulses every 2 cycles and seg_en stays 0.
